shift_fifo: RTL

Parametrised shift-register FIFO for the regular-expression checker datapath: a chain of DEPTH identical stages where new words settle into the lowest empty stage and stage 0 always presents the oldest word. It replaces hand-chained single stages with one block that adds depth/width parameters, occupancy count, almost-full flag, synchronous flush and guarded overflow/underflow. It sits between the character source and the match engine.

---
 rtl/shift_fifo_pkg.sv | 13 +
 rtl/shift_fifo_cell.sv | 61 ++++++
 rtl/shift_fifo.sv | 118 +++++++++++
 3 files changed

// File: rtl/shift_fifo_pkg.sv
// Shared constants and helpers for the shift-register FIFO.
package shift_fifo_pkg;

    localparam int unsigned DefaultWidth = 64;
    localparam int unsigned MinDepth     = 2;
    localparam int unsigned MaxDepth     = 64;

    // Width of an occupancy counter that must represent 0..depth inclusive.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/shift_fifo_cell.sv
// One FIFO stage: holds an occupancy bit and a word. On a pop it takes its upper
// neighbour; a push lands in the lowest empty stage (or the stage just vacated
// when pushing and popping together).
module shift_fifo_cell
    import shift_fifo_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth,
    parameter int unsigned INDEX = 0,
    parameter int unsigned CW    = 4
) (
    input  logic             clk_i,
    input  logic             res_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [CW-1:0]    count_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             upper_occ_i,
    input  logic [WIDTH-1:0] upper_word_i,
    output logic             occ_o,
    output logic [WIDTH-1:0] word_o
);

    logic             occ_q, occ_d;
    logic [WIDTH-1:0] word_q, word_d;

    // Select hold / shift-down / new word; empty stages always carry zero.
    always_comb begin
        occ_d  = occ_q;
        word_d = word_q;
        if (flush_i) begin
            occ_d  = 1'b0;
            word_d = '0;
        end else if (pop_i) begin
            occ_d  = upper_occ_i;
            word_d = upper_word_i;
            if (push_i && count_i == CW'(INDEX + 1)) begin
                occ_d  = 1'b1;
                word_d = data_i;
            end
        end else if (push_i && count_i == CW'(INDEX)) begin
            occ_d  = 1'b1;
            word_d = data_i;
        end
    end

    // Stage state register.
    always_ff @(posedge clk_i or posedge res_i) begin
        if (res_i) begin
            occ_q  <= 1'b0;
            word_q <= '0;
        end else begin
            occ_q  <= occ_d;
            word_q <= word_d;
        end
    end

    assign occ_o  = occ_q;
    assign word_o = word_q;

endmodule

// File: rtl/shift_fifo.sv
// Parametrised shift-register FIFO; stage 0 always presents the oldest word.
// Optional sticky overflow/underflow outputs are enabled by SHIFT_FIFO_ERR_EN.
module shift_fifo
    import shift_fifo_pkg::*;
#(
    parameter int unsigned WIDTH    = DefaultWidth,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned AF_LEVEL = DEPTH - 1
) (
    input  logic                          clk,
    input  logic                          res,
    input  logic                          shift_in,
    input  logic [WIDTH-1:0]              data_in,
    input  logic                          shift_out,
    input  logic                          flush,
    output logic [WIDTH-1:0]              data_out,
    output logic                          empty,
    output logic                          full,
    output logic                          almost_full,
    output logic [cnt_width(DEPTH)-1:0]   count,
    output logic                          accepted_in,
    output logic                          accepted_out
`ifdef SHIFT_FIFO_ERR_EN
    ,
    output logic                          overflow,
    output logic                          underflow
`endif
);

    localparam int unsigned CntW = cnt_width(DEPTH);

    logic [CntW-1:0]  count_q, count_d;
    logic [DEPTH-1:0] occ;
    logic [WIDTH-1:0] word [DEPTH];

    assign empty        = (count_q == '0);
    assign full         = (count_q == CntW'(DEPTH));
    assign almost_full  = (32'(count_q) >= AF_LEVEL);
    assign count        = count_q;
    assign accepted_in  = shift_in & (~full | shift_out) & ~flush;
    assign accepted_out = shift_out & ~empty & ~flush;
    // Unoccupied stages hold zero anyway; the gate keeps that explicit at the head.
    assign data_out     = occ[0] ? word[0] : '0;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             upper_occ;
        logic [WIDTH-1:0] upper_word;

        if (i == DEPTH - 1) begin : g_top
            assign upper_occ  = 1'b0;
            assign upper_word = '0;
        end else begin : g_mid
            assign upper_occ  = occ[i+1];
            assign upper_word = word[i+1];
        end

        shift_fifo_cell #(
            .WIDTH (WIDTH),
            .INDEX (i),
            .CW    (CntW)
        ) u_cell (
            .clk_i        (clk),
            .res_i        (res),
            .flush_i      (flush),
            .push_i       (accepted_in),
            .pop_i        (accepted_out),
            .count_i      (count_q),
            .data_i       (data_in),
            .upper_occ_i  (upper_occ),
            .upper_word_i (upper_word),
            .occ_o        (occ[i]),
            .word_o       (word[i])
        );
    end

    // Occupancy count: +1 on push, -1 on pop, unchanged on both or neither.
    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else if (accepted_in && !accepted_out) begin
            count_d = count_q + 1'b1;
        end else if (!accepted_in && accepted_out) begin
            count_d = count_q - 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

`ifdef SHIFT_FIFO_ERR_EN
    logic overflow_q, underflow_q;

    // Sticky error flags for dropped pushes and pops; flush clears them.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (flush) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (shift_in && full && !shift_out) overflow_q <= 1'b1;
            if (shift_out && empty) underflow_q <= 1'b1;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`endif

endmodule
